// File: rtl/uart_loan_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_loan_pkg : shared types and constants for the loan-IO UART TX    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package uart_loan_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int LOAN_WIDTH = 67;

  // Clocks per bit, rounded to nearest.
  function automatic int div_calc(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_fifo : small synchronous byte FIFO feeding the UART framer    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cnt_w = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign full      = (r_count == c_cnt_w'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;
  assign dout      = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_loan_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_loan_tx : 8N1 UART transmitter on one HPS loan-IO bit            |
// | Optional even parity (8E1) when UART_TX_PARITY_EN is defined.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module uart_loan_tx
  import uart_loan_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int LOAN_IDX   = 50,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_busy,
  output logic [LOAN_WIDTH-1:0] loan_io_out,
  output logic [LOAN_WIDTH-1:0] loan_io_oe
);

  localparam int c_div   = div_calc(CLK_HZ, BAUD);
  localparam int c_cnt_w = (c_div > 1) ? $clog2(c_div) : 1;
`ifdef UART_TX_PARITY_EN
  localparam tx_state_t c_after_data = PARITY;
`else
  localparam tx_state_t c_after_data = STOP;
`endif

  tx_state_t          r_state;
  logic [c_cnt_w-1:0] r_baud_cnt;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_shift;
  logic               r_parity;
  logic               r_line;
  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic [7:0]         w_dout;
  logic               w_bit_end;
  logic               w_line_nxt;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (tx_valid),
    .pop     (w_pop),
    .din     (tx_data),
    .dout    (w_dout),
    .full    (w_full),
    .empty   (w_empty)
  );

  assign tx_ready  = ~w_full;
  assign tx_busy   = (r_state != IDLE) | ~w_empty;
  assign w_bit_end = (r_baud_cnt == c_cnt_w'(c_div - 1));
  assign w_pop     = ~w_empty & ((r_state == IDLE) | ((r_state == STOP) & w_bit_end));

  // Line level follows the current state, so the pin lags the FSM by one clock.
  always_comb begin
    w_line_nxt = 1'b1;
    case (r_state)
      START:   w_line_nxt = 1'b0;
      DATA:    w_line_nxt = r_shift[0];
      PARITY:  w_line_nxt = r_parity;
      default: w_line_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_line     <= 1'b1;
    end else begin
      r_line <= w_line_nxt;
      if (r_state != IDLE)
        r_baud_cnt <= w_bit_end ? '0 : r_baud_cnt + c_cnt_w'(1);
      case (r_state)
        IDLE: begin
          r_baud_cnt <= '0;
          if (!w_empty) begin
            r_shift  <= w_dout;
            r_parity <= ^w_dout;
            r_state  <= START;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_bit_idx <= '0;
            r_state   <= DATA;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_shift <= {1'b0, r_shift[7:1]};
            if (r_bit_idx == 3'd7) r_state <= c_after_data;
            else                   r_bit_idx <= r_bit_idx + 3'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (w_bit_end) r_state <= STOP;
        end
`endif
        STOP: begin
          if (w_bit_end) begin
            if (!w_empty) begin
              r_shift  <= w_dout;
              r_parity <= ^w_dout;
              r_state  <= START;
            end else begin
              r_state  <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < LOAN_WIDTH; gi++) begin : g_loan_bit
    if (gi == LOAN_IDX) begin : g_drive
      assign loan_io_out[gi] = r_line;
      assign loan_io_oe[gi]  = 1'b1;
    end else begin : g_tie
      assign loan_io_out[gi] = 1'b0;
      assign loan_io_oe[gi]  = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_loan_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_loan_tx : scoreboard bench for uart_loan_tx (DIV = 10)        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_uart_loan_tx;

  localparam int DIV  = 10;
  localparam int LIDX = 50;
`ifdef UART_TX_PARITY_EN
  localparam int NPER = 11;
`else
  localparam int NPER = 10;
`endif

  logic        clk      = 1'b0;
  logic        reset_n  = 1'b0;
  logic [7:0]  tx_data  = 8'h00;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic        tx_busy;
  logic [66:0] loan_io_out;
  logic [66:0] loan_io_oe;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;
  logic [7:0]  sb [$];

  uart_loan_tx #(
    .CLK_HZ     (1000),
    .BAUD       (100),
    .LOAN_IDX   (LIDX),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_busy     (tx_busy),
    .loan_io_out (loan_io_out),
    .loan_io_oe  (loan_io_oe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called just after a clock edge; returns just after the accepting edge.
  task automatic send(input logic [7:0] b, output int acc);
    int t;
    t = 0;
    acc = -1;
    tx_data  = b;
    tx_valid = 1'b1;
    while (!tx_ready) begin
      @(posedge clk); #1;
      t++;
      if (t > 2000) begin
        chk("send_timeout", 1, 0);
        tx_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    acc = cyc;
    sb.push_back(b);
    tx_valid = 1'b0;
  endtask

  // Detect a falling edge, then sample each bit mid-period.
  task automatic rx_frame(output int st);
    logic       prev, cur;
    logic [7:0] d, e;
    int         t;
    t  = 0;
    st = -1;
    prev = loan_io_out[LIDX];
    forever begin
      @(negedge clk);
      cur = loan_io_out[LIDX];
      if (prev && !cur) break;
      prev = cur;
      t++;
      if (t > 3000) begin
        chk("rx_timeout", 1, 0);
        return;
      end
    end
    st = cyc;
    repeat (DIV / 2) @(negedge clk);
    chk("start_bit", loan_io_out[LIDX], 0);
    for (int i = 0; i < 8; i++) begin
      repeat (DIV) @(negedge clk);
      d[i] = loan_io_out[LIDX];
    end
    if (sb.size() == 0) begin
      chk("sb_underflow", 1, 0);
      e = 8'h00;
    end else begin
      e = sb.pop_front();
    end
    chk("rx_data", d, e);
`ifdef UART_TX_PARITY_EN
    repeat (DIV) @(negedge clk);
    chk("parity_bit", loan_io_out[LIDX], ^e);
`endif
    repeat (DIV) @(negedge clk);
    chk("stop_bit", loan_io_out[LIDX], 1);
  endtask

  // Exact per-clock waveform of one frame sent into an idle block.
  task automatic wave_check(input logic [7:0] b);
    int         acc;
    logic [7:0] e;
    logic       bv;
    logic [31:0] vec;
    send(b, acc);
    e = sb.pop_front();
    @(posedge clk); #1;
    chk("pre_start_line", loan_io_out[LIDX], 1);
    chk("busy_in_frame", tx_busy, 1);
    for (int j = 0; j < NPER; j++) begin
      vec = '0;
      for (int s = 0; s < DIV; s++) begin
        @(posedge clk); #1;
        vec[s] = loan_io_out[LIDX];
      end
      if (j == 0)                   bv = 1'b0;
      else if (j <= 8)              bv = e[j-1];
      else if (j == 9 && NPER == 11) bv = ^e;
      else                          bv = 1'b1;
      chk($sformatf("wave_%02h_bit%0d", b, j), vec, bv ? 32'((1 << DIV) - 1) : 32'd0);
    end
    chk("busy_after_frame", tx_busy, 0);
  endtask

  initial begin
    int   acc0, acc, t, lows;
    int   st [5];
    logic [66:0] exp_oe;

    exp_oe = '0;
    exp_oe[LIDX] = 1'b1;

    // Reset state
    repeat (3) @(posedge clk); #1;
    chk("rst_line", loan_io_out[LIDX], 1);
    chk("rst_out_vec", 32'(loan_io_out == exp_oe), 1);
    chk("rst_oe_vec", 32'(loan_io_oe == exp_oe), 1);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", tx_busy, 0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Single frames: exact waveform, including the parity case bytes
    wave_check(8'h55);
    wave_check(8'h07);
    wave_check(8'h03);

    // Back-to-back burst fills the FIFO; frames must be contiguous
    fork
      begin
        send(8'h00, acc0);
        send(8'hFF, acc);
        send(8'hA5, acc);
        send(8'h3C, acc);
        send(8'h81, acc);
        chk("ready_when_full", tx_ready, 0);
      end
      begin
        for (int i = 0; i < 5; i++) rx_frame(st[i]);
      end
    join
    chk("first_start_latency", st[0] - acc0, 2);
    for (int i = 1; i < 5; i++) chk($sformatf("frame_gap%0d", i), st[i] - st[i-1], NPER * DIV);
    @(posedge clk); #1;
    t = 0;
    while (tx_busy && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    chk("busy_fall", cyc - acc0, 1 + 5 * NPER * DIV);

    // Push held while full across a pop: ignored, count ends at 3
    fork
      begin
        send(8'h11, acc);
        send(8'h22, acc);
        send(8'h33, acc);
        send(8'h44, acc);
        send(8'h5A, acc);
        tx_data  = 8'hEE;
        tx_valid = 1'b1;
        t = 0;
        do begin
          @(posedge clk); #1;
          t++;
        end while (!tx_ready && t < 2000);
        tx_valid = 1'b0;
        chk("full_wait_timeout", 32'(t < 2000), 1);
        chk("count_after_pop", 32'(dut.u_fifo.r_count), 3);
        chk("busy_while_queued", tx_busy, 1);
      end
      begin
        for (int i = 0; i < 5; i++) rx_frame(st[i]);
      end
    join
    @(posedge clk); #1;

    // Reset mid-frame: line returns high at once, nothing else goes out
    send(8'h0F, acc);
    void'(sb.pop_front());
    repeat (2 + 5 * DIV + 3) @(posedge clk);
    #1;
    chk("pre_rst_data_bit", loan_io_out[LIDX], 0);
    reset_n = 1'b0;
    #1;
    chk("abort_line", loan_io_out[LIDX], 1);
    chk("abort_busy", tx_busy, 0);
    chk("abort_ready", tx_ready, 1);
    repeat (3) @(posedge clk); #1;
    reset_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 15 * DIV; i++) begin
      @(posedge clk); #1;
      if (!loan_io_out[LIDX]) lows++;
    end
    chk("no_frame_after_rst", lows, 0);
    send(8'h96, acc);
    rx_frame(st[0]);
    chk("post_rst_latency", st[0] - acc, 2);

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
